updown_counter_sevenseg: RTL and testbench

Parametrised up/down counter with a hex seven-segment display driver. It is the successor to the single-digit board counter.
- Counts on debounced, edge-detected key presses in the system clock domain; the key is not used as a clock.
- Supports configurable width, wrap or saturate at the limits, synchronous load, and multi-digit time-multiplexed display.
- Sits between the board key/switch inputs and the HEX display pins.

---
 rtl/updown_counter_sevenseg_if.sv | 27 ++
 rtl/updown_counter_sevenseg.sv | 160 ++++++++++++++++
 tb/tb_updown_counter_sevenseg.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/updown_counter_sevenseg_if.sv
// Board-side bundle for the up/down counter: key/switch inputs toward the
// counter, count status and HEX display pins back out.
interface updown_counter_sevenseg_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = WIDTH / 4
);
    logic              key_n;
    logic              up;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic              enable;
    logic [WIDTH-1:0]  count;
    logic              at_limit;
    logic              press;
    logic [6:0]        seg;
    logic [DIGITS-1:0] dig_sel;

    modport master (
        output key_n, up, load, load_val, enable,
        input  count, at_limit, press, seg, dig_sel
    );

    modport slave (
        input  key_n, up, load, load_val, enable,
        output count, at_limit, press, seg, dig_sel
    );
endinterface

// File: rtl/updown_counter_sevenseg.sv
// Up/down counter driven by a debounced push-button, with a time-multiplexed
// hex seven-segment display of the count.
module updown_counter_sevenseg #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DIGITS          = WIDTH / 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned SCAN_DIV        = 1024,
    parameter bit          SATURATE        = 1'b0,
    parameter bit          SEG_ACTIVE_LOW  = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    updown_counter_sevenseg_if.slave  bus
);
    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [6:0]        SEG_BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    typedef enum logic [1:0] {REL, PRESS_PEND, HELD, REL_PEND} db_state_e;

    logic              key_meta_q, key_sync_q;
    db_state_e         db_state_q;
    logic [DB_W-1:0]   db_cnt_q;
    logic              press_q;
    logic [WIDTH-1:0]  count_q, count_d;
    logic [SCAN_W-1:0] scan_q;
    logic [IDX_W-1:0]  idx_q;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] dig_sel_q, dig_sel_d;
    logic [WIDTH-1:0]  count_shift;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        unique case (nib)
            4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
            4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
            4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
            4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  4'hF: g = 7'h71;
        endcase
        return g;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
        end else begin
            key_meta_q <= bus.key_n;
            key_sync_q <= key_meta_q;
        end
    end

    // The sample that moves out of a stable state counts as the first of the
    // DEBOUNCE_CYCLES equal samples, giving press 2+DEBOUNCE_CYCLES after key_n.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_state_q <= REL;
            db_cnt_q   <= '0;
            press_q    <= 1'b0;
        end else begin
            press_q <= 1'b0;
            unique case (db_state_q)
                REL: if (!key_sync_q) begin
                    if (DEBOUNCE_CYCLES <= 1) begin
                        db_state_q <= HELD;
                        press_q    <= 1'b1;
                    end else begin
                        db_state_q <= PRESS_PEND;
                        db_cnt_q   <= DB_W'(1);
                    end
                end
                PRESS_PEND: begin
                    if (key_sync_q) begin
                        db_state_q <= REL;
                    end else if (db_cnt_q == DB_LAST) begin
                        db_state_q <= HELD;
                        press_q    <= 1'b1;
                    end else begin
                        db_cnt_q <= db_cnt_q + DB_W'(1);
                    end
                end
                HELD: if (key_sync_q) begin
                    if (DEBOUNCE_CYCLES <= 1) begin
                        db_state_q <= REL;
                    end else begin
                        db_state_q <= REL_PEND;
                        db_cnt_q   <= DB_W'(1);
                    end
                end
                REL_PEND: begin
                    if (!key_sync_q) begin
                        db_state_q <= HELD;
                    end else if (db_cnt_q == DB_LAST) begin
                        db_state_q <= REL;
                    end else begin
                        db_cnt_q <= db_cnt_q + DB_W'(1);
                    end
                end
                default: db_state_q <= REL;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        if (bus.load) begin
            count_d = bus.load_val;
        end else if (press_q && bus.enable) begin
            if (bus.up) begin
                count_d = (SATURATE && (&count_q)) ? count_q : count_q + 1'b1;
            end else begin
                count_d = (SATURATE && (count_q == '0)) ? count_q : count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_q <= '0;
            idx_q  <= '0;
        end else if (scan_q == SCAN_LAST) begin
            scan_q <= '0;
            idx_q  <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
            scan_q <= scan_q + SCAN_W'(1);
        end
    end

    // Segment and digit-enable registers follow idx_q by one cycle together.
    always_comb begin
        count_shift = count_q >> {idx_q, 2'b00};
        seg_d       = hex_glyph(count_shift[3:0]) ^ {7{SEG_ACTIVE_LOW}};
        dig_sel_d   = DIGITS'(1) << idx_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q     <= SEG_BLANK;
            dig_sel_q <= DIGITS'(1);
        end else begin
            seg_q     <= seg_d;
            dig_sel_q <= dig_sel_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.press    = press_q;
    assign bus.seg      = seg_q;
    assign bus.dig_sel  = dig_sel_q;
    assign bus.at_limit = bus.up ? (&count_q) : ~(|count_q);
endmodule

// File: tb/tb_updown_counter_sevenseg.sv
// Bench for updown_counter_sevenseg: a wrapping and a saturating instance share
// one stimulus stream and are compared against an arithmetic count model.
module tb_updown_counter_sevenseg;
    localparam int unsigned DBC = 16;
    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic       clk = 1'b0;
    logic       reset;
    logic       key_n, up, load, enable;
    logic [7:0] load_val;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int npress_w = 0;
    int npress_s = 0;
    logic [7:0] mw = 8'h00;
    logic [7:0] ms = 8'h00;

    updown_counter_sevenseg_if #(.WIDTH(8), .DIGITS(2)) ifw ();
    updown_counter_sevenseg_if #(.WIDTH(8), .DIGITS(2)) ifs ();

    assign ifw.key_n = key_n;    assign ifs.key_n = key_n;
    assign ifw.up = up;          assign ifs.up = up;
    assign ifw.load = load;      assign ifs.load = load;
    assign ifw.load_val = load_val;  assign ifs.load_val = load_val;
    assign ifw.enable = enable;  assign ifs.enable = enable;

    updown_counter_sevenseg #(
        .WIDTH(8), .DIGITS(2), .DEBOUNCE_CYCLES(DBC), .SCAN_DIV(4),
        .SATURATE(1'b0), .SEG_ACTIVE_LOW(1'b1)
    ) dut_w (.clk(clk), .reset(reset), .bus(ifw));

    updown_counter_sevenseg #(
        .WIDTH(8), .DIGITS(2), .DEBOUNCE_CYCLES(DBC), .SCAN_DIV(4),
        .SATURATE(1'b1), .SEG_ACTIVE_LOW(1'b1)
    ) dut_s (.clk(clk), .reset(reset), .bus(ifs));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ifw.press === 1'b1) npress_w++;
        if (ifs.press === 1'b1) npress_s++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] step(input logic [7:0] c, input bit u, input bit sat);
        int v;
        v = u ? int'(c) + 1 : int'(c) - 1;
        if (v > 255)    v = sat ? 255 : 0;
        else if (v < 0) v = sat ? 0 : 255;
        return v[7:0];
    endfunction

    function automatic logic lim(input logic [7:0] c, input bit u);
        return u ? (c == 8'hFF) : (c == 8'h00);
    endfunction

    task automatic load_value(input logic [7:0] v);
        load_val = v;
        load     = 1'b1;
        tick(1);
        load = 1'b0;
        mw = v;
        ms = v;
        chk("load_w", ifw.count, mw);
        chk("load_s", ifs.count, ms);
    endtask

    // Key starts released; toggles (even) bounce it every 5 cycles before the final low.
    task automatic do_press(input int toggles, input bit ld_same, input logic [7:0] ldv,
                            input bit flip_up);
        int c0w, c0s, t0, lat;
        bit seen, u, en;
        c0w = npress_w;
        c0s = npress_s;
        for (int i = 0; i < toggles; i++) begin
            key_n = ~key_n;
            tick(5);
        end
        key_n = 1'b0;
        t0    = cyc;
        seen  = 1'b0;
        lat   = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick(1);
            if (ifw.press === 1'b1) begin
                seen = 1'b1;
                lat  = cyc - t0;
            end
        end
        chk("press_seen", 32'(seen), 1);
        if (seen) begin
            chk("press_latency", lat, DBC + 2);
            chk("press_s_aligned", ifs.press, 1);
        end
        u  = up;
        en = enable;
        if (ld_same) begin
            load_val = ldv;
            load     = 1'b1;
        end
        tick(1);
        load = 1'b0;
        if (ld_same) begin
            mw = ldv;
            ms = ldv;
        end else if (en) begin
            mw = step(mw, u, 1'b0);
            ms = step(ms, u, 1'b1);
        end
        chk("count_w", ifw.count, mw);
        chk("count_s", ifs.count, ms);
        chk("at_limit_w", ifw.at_limit, lim(mw, u));
        chk("at_limit_s", ifs.at_limit, lim(ms, u));
        chk("press_single", ifw.press, 0);
        if (flip_up) up = ~up;
        tick(10);
        chk("held_count_w", ifw.count, mw);
        chk("held_count_s", ifs.count, ms);
        key_n = 1'b1;
        tick(DBC + 8);
        chk("press_pulses_w", npress_w - c0w, 1);
        chk("press_pulses_s", npress_s - c0s, 1);
    endtask

    task automatic scan_check(input int n);
        logic [1:0] prev;
        logic [3:0] nib;
        int run;
        bit first;
        prev  = ifw.dig_sel;
        run   = 0;
        first = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick(1);
            chk("dig_sel_onehot", 32'(ifw.dig_sel == 2'b01 || ifw.dig_sel == 2'b10), 1);
            nib = (ifw.dig_sel == 2'b10) ? mw[7:4] : mw[3:0];
            chk("seg_glyph", ifw.seg, {25'd0, ~GLYPH[nib]});
            if (ifw.dig_sel != prev) begin
                if (!first) chk("scan_period", run, 4);
                first = 1'b0;
                run   = 1;
                prev  = ifw.dig_sel;
            end else begin
                run++;
            end
        end
    endtask

    initial begin
        logic [7:0] picks [4];
        int n0;
        picks = '{8'h00, 8'hFF, 8'h01, 8'hFE};
        reset = 1'b1; key_n = 1'b1; up = 1'b1; load = 1'b0; load_val = 8'h00; enable = 1'b1;
        tick(3);
        chk("rst_count_w", ifw.count, 0);
        chk("rst_count_s", ifs.count, 0);
        chk("rst_press", ifw.press, 0);
        chk("rst_dig_sel", ifw.dig_sel, 2'b01);
        chk("rst_seg_blank", ifw.seg, 7'h7F);
        reset = 1'b0;
        tick(20);

        for (int i = 0; i < 3; i++) do_press(0, 1'b0, 8'h00, 1'b0);
        chk("three_presses", ifw.count, 3);
        scan_check(12);

        do_press(8, 1'b0, 8'h00, 1'b0);

        up = 1'b1;
        load_value(8'hFF);
        do_press(0, 1'b0, 8'h00, 1'b0);
        up = 1'b0;
        load_value(8'h00);
        do_press(0, 1'b0, 8'h00, 1'b0);

        up = 1'b1;
        load_value(8'h10);
        do_press(0, 1'b1, 8'h5A, 1'b0);

        enable = 1'b0;
        do_press(0, 1'b0, 8'h00, 1'b0);
        do_press(2, 1'b0, 8'h00, 1'b1);
        enable = 1'b1;

        load_value(8'hC7);
        tick(2);
        scan_check(20);

        key_n = 1'b0;
        tick(8);
        reset = 1'b1;
        key_n = 1'b1;
        tick(3);
        mw = 8'h00;
        ms = 8'h00;
        chk("mid_rst_count_w", ifw.count, mw);
        chk("mid_rst_count_s", ifs.count, ms);
        reset = 1'b0;
        n0 = npress_w;
        tick(40);
        chk("mid_rst_no_press", npress_w - n0, 0);
        chk("mid_rst_count_after", ifw.count, 0);

        for (int i = 0; i < 12; i++) begin
            up     = 1'($urandom_range(0, 1));
            enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) load_value(picks[$urandom_range(0, 3)]);
            do_press(int'(2 * $urandom_range(0, 4)), ($urandom_range(0, 4) == 0),
                     8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
